// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU register bank and its read ports.
package cpu_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned REG_COUNT = 8;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam data_t ZERO_DATA = '0;

  // Per-port read state: VALID means rd_data was loaded at the last edge.
  typedef enum logic {
    StIdle,
    StValid
  } port_state_e;

endpackage

// File: rtl/register_file_read_port_if.sv
// Write port plus two read request/response channels of the register bank.
interface register_file_read_port_if;
  import cpu_pkg::*;

  logic      wr_en;
  reg_addr_t wr_addr;
  data_t     wr_data;

  logic      rd_en_a;
  reg_addr_t rd_addr_a;
  data_t     rd_data_a;
  logic      rd_valid_a;

  logic      rd_en_b;
  reg_addr_t rd_addr_b;
  data_t     rd_data_b;
  logic      rd_valid_b;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
  );

endinterface

// File: rtl/rf_read_port.sv
// One registered read port: address mux over the flat storage bus, write bypass
// and the valid flag.
module rf_read_port
  import cpu_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [REG_COUNT*DATA_W-1:0] mem_flat,
  input  logic                        wr_en,
  input  reg_addr_t                   wr_addr,
  input  data_t                       wr_data,
  input  logic                        rd_en,
  input  reg_addr_t                   rd_addr,
  output data_t                       rd_data,
  output logic                        rd_valid
);

  port_state_e state_q, state_d;
  data_t       data_q, data_d;
  logic        bypass;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    // Same-edge write to the requested register wins over the stored value.
    bypass  = wr_en && (wr_addr == rd_addr);

    unique case (state_q)
      StIdle:  if (rd_en)  state_d = StValid;
      StValid: if (!rd_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (rd_en) begin
      data_d = bypass ? wr_data : mem_flat[int'(rd_addr)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= ZERO_DATA;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign rd_data  = data_q;
  assign rd_valid = (state_q == StValid);

endmodule

// File: rtl/register_file_read_port.sv
// 8 x 16-bit register bank with one write port and two independent registered
// read ports (A and B), each with write-to-read bypass.
module register_file_read_port
  import cpu_pkg::*;
(
  input logic                        clk,
  input logic                        rst_n,
  register_file_read_port_if.slave   bus
);

  data_t                       mem_q [REG_COUNT];
  logic [REG_COUNT*DATA_W-1:0] mem_flat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        mem_q[i] <= ZERO_DATA;
      end
    end else if (bus.wr_en) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar g = 0; g < int'(REG_COUNT); g++) begin : g_flat
    assign mem_flat[g*DATA_W +: DATA_W] = mem_q[g];
  end

  rf_read_port port_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_flat (mem_flat),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .rd_en    (bus.rd_en_a),
    .rd_addr  (bus.rd_addr_a),
    .rd_data  (bus.rd_data_a),
    .rd_valid (bus.rd_valid_a)
  );

  rf_read_port port_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_flat (mem_flat),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .rd_en    (bus.rd_en_b),
    .rd_addr  (bus.rd_addr_b),
    .rd_data  (bus.rd_data_b),
    .rd_valid (bus.rd_valid_b)
  );

endmodule

// File: tb/tb_register_file_read_port.sv
// Directed vector bench for register_file_read_port.
module tb_register_file_read_port;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  register_file_read_port_if rf_if ();

  register_file_read_port dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic      wr_en;
    reg_addr_t wr_addr;
    data_t     wr_data;
    logic      en_a;
    reg_addr_t addr_a;
    logic      en_b;
    reg_addr_t addr_b;
    logic      exp_va;
    data_t     exp_da;
    logic      exp_vb;
    data_t     exp_db;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_ports(input string tag, input logic va, input data_t da,
                             input logic vb, input data_t db);
    check({tag, "_valid_a"}, {15'd0, rf_if.rd_valid_a}, {15'd0, va});
    check({tag, "_data_a"},  rf_if.rd_data_a, da);
    check({tag, "_valid_b"}, {15'd0, rf_if.rd_valid_b}, {15'd0, vb});
    check({tag, "_data_b"},  rf_if.rd_data_b, db);
  endtask

  task automatic drive(input logic we, input reg_addr_t wa, input data_t wd,
                       input logic ea, input reg_addr_t aa, input logic eb,
                       input reg_addr_t ab);
    rf_if.wr_en     = we;
    rf_if.wr_addr   = wa;
    rf_if.wr_data   = wd;
    rf_if.rd_en_a   = ea;
    rf_if.rd_addr_a = aa;
    rf_if.rd_en_b   = eb;
    rf_if.rd_addr_b = ab;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //            we    wa    wd        ea    aa    eb    ab    va    da        vb    db
    vecs[0] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b0, 3'd0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 3'd2, 16'hAAAA, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[2] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 3'd0, 1'b1, 16'hAAAA, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 16'hAAAA, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 3'd3, 16'h5555, 1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 16'h5555, 1'b1, 16'h5555};
    vecs[5] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 16'h5555, 1'b1, 16'h5555};
    vecs[6] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 3'd0, 1'b1, 16'hAAAA, 1'b0, 16'h5555};
    vecs[7] = '{1'b1, 3'd2, 16'hFFFF, 1'b0, 3'd2, 1'b0, 3'd0, 1'b0, 16'hAAAA, 1'b0, 16'h5555};
    vecs[8] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 3'd0, 1'b1, 16'hFFFF, 1'b0, 16'h5555};
    vecs[9] = '{1'b1, 3'd1, 16'h0BEE, 1'b1, 3'd2, 1'b1, 3'd1, 1'b1, 16'hFFFF, 1'b1, 16'h0BEE};

    // Reset held from time 0 with requests and a write pending: nothing may load.
    rst_n = 1'b0;
    drive(1'b1, 3'd5, 16'hFFFF, 1'b1, 3'd5, 1'b1, 3'd5);
    #1;
    check_ports("rst_t0", 1'b0, 16'h0000, 1'b0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check_ports("rst_held", 1'b0, 16'h0000, 1'b0, 16'h0000);

    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data,
            vecs[i].en_a, vecs[i].addr_a, vecs[i].en_b, vecs[i].addr_b);
      step();
      check_ports($sformatf("vec%0d", i), vecs[i].exp_va, vecs[i].exp_da,
                  vecs[i].exp_vb, vecs[i].exp_db);
    end

    // Fill r0..r7 with 0x1111*i while both ports idle and hold.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, reg_addr_t'(i), data_t'(32'h1111 * i), 1'b0, 3'd0, 1'b0, 3'd0);
      step();
      check_ports($sformatf("fill%0d", i), 1'b0, 16'hFFFF, 1'b0, 16'h0BEE);
    end

    // Back-to-back streaming, A ascending and B descending.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'd0, 16'h0000, 1'b1, reg_addr_t'(i), 1'b1, reg_addr_t'(7 - i));
      step();
      check_ports($sformatf("stream%0d", i), 1'b1, data_t'(32'h1111 * i),
                  1'b1, data_t'(32'h1111 * (7 - i)));
    end

    // Reset asserted between edges mid-stream, with a write in flight.
    drive(1'b1, 3'd4, 16'hBEEF, 1'b1, 3'd0, 1'b1, 3'd7);
    step();
    check_ports("pre_rst", 1'b1, 16'h0000, 1'b1, 16'h7777);
    drive(1'b1, 3'd4, 16'hBEEF, 1'b1, 3'd1, 1'b1, 3'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check_ports("rst_mid", 1'b0, 16'h0000, 1'b0, 16'h0000);
    step();
    check_ports("rst_mid_edge", 1'b0, 16'h0000, 1'b0, 16'h0000);

    rst_n = 1'b1;
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b0, 3'd0);
    step();
    check_ports("post_rst_r4", 1'b1, 16'h0000, 1'b0, 16'h0000);
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd7);
    step();
    check_ports("post_rst_r7", 1'b0, 16'h0000, 1'b1, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_read_port.md
Name: register_file_read_port

Overview:
- Read side of the CPU register storage: an 8 x 16-bit register bank with one write port and two independent registered read ports (A and B).
- Feeds ALU operands in the simple CPU datapath.
- Each read port has a request/valid handshake and write-to-read bypass, so an operand written in the same cycle is returned without a stall.

Parameters:
- DATA_W, 16, width of each register and each data port.
- ADDR_W, 3, register address width.
- REG_COUNT, 8, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  register written when wr_en=1.
- wr_data  input  DATA_W  write data.
- rd_en_a  input  1  read request, port A.
- rd_addr_a  input  ADDR_W  read address, port A.
- rd_data_a  output  DATA_W  registered read data, port A.
- rd_valid_a  output  1  rd_data_a updated by the request of the previous cycle.
- rd_en_b, rd_addr_b, rd_data_b, rd_valid_b: same as port A, for port B.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- rst_n=0, immediately and independent of clk:
  - all REG_COUNT registers = 0
  - rd_data_a = rd_data_b = 0
  - rd_valid_a = rd_valid_b = 0
- Reset release: first active edge is the first rising clk with rst_n=1.
- Write: at a rising edge with wr_en=1, mem[wr_addr] <= wr_data. With wr_en=0, storage holds. No write-protected registers; register 0 is writable.
- Read, latency 1 cycle. At a rising edge with rd_en_x=1:
  - rd_data_x <= bypass ? wr_data : mem[rd_addr_x]
  - bypass = wr_en && (wr_addr == rd_addr_x), sampled at the same edge
  - rd_valid_x <= 1
- Read idle: at a rising edge with rd_en_x=0, rd_valid_x <= 0 and rd_data_x holds its last value (never cleared except by reset).
- Back-to-back requests: valid stays high continuously; data updates every cycle.
- Port independence:
  - A and B may read the same address in the same cycle; both return identical data.
  - Bypass is evaluated per port.
- Write with no read: the result is visible to a read requested on the next edge or later.
- Reset mid-operation:
  - Pending reads are discarded; valid drops immediately.
  - Any write at the same edge as reset assertion is lost.
- Arithmetic: none. Addresses are unsigned. REG_COUNT is a power of two, so out-of-range addresses cannot occur.
- No internal state machine beyond the per-port valid flops. Each port is two states, IDLE (valid=0) and VALID (valid=1), with transition on rd_en_x.

Decomposition:
- Shared package cpu_pkg: DATA_W, ADDR_W, REG_COUNT constants; register address type; zero constant for reset values.
- One natural sub-module: rf_read_port.
  - Contents: registered output mux, bypass compare and valid flop.
  - Instantiated twice (A, B).
  - Inputs: the storage array as a flat bus and the write-port signals.
- Storage and write logic live in the top module.

Test Plan:
- Reset check: hold rst_n=0 and drive rd_en_a=rd_en_b=1 -> rd_data_a=rd_data_b=16'h0000 and both valids 0 with no clk edge needed; after release, read addr 5 -> 16'h0000, valid=1 one cycle later.
- Write then read: write 16'hAAAA to r2, next cycle read r2 on port A -> rd_data_a=16'hAAAA, rd_valid_a=1 exactly one edge after the request.
- Bypass: r3=16'h1234; in one cycle write 16'h5555 to r3 and read r3 on both ports -> both return 16'h5555 (not 16'h1234); r3 reads 16'h5555 afterwards.
- Hold on idle: read r2 (16'hAAAA), then drop rd_en_a while writing 16'hFFFF to r2 -> rd_valid_a=0 and rd_data_a stays 16'hAAAA; re-enable -> 16'hFFFF.
- Dual-port streaming: fill r0..r7 with 16'h1111*i. Stream A over 0..7 and B over 7..0 back-to-back -> valids stay 1, data matches each cycle, A and B in the same cycle never interfere.
- Reset mid-stream: assert rst_n between clk edges during streaming -> outputs and valids go to 0 immediately. After release, a read of r4 returns 16'h0000.
